pc_sequencer: RTL and testbench

Control-flow partner of program_counter. It drives the counter's set/set_value inputs and consumes its count output.
- Watches the instruction returned by a one-cycle-latency synchronous program ROM (addressed directly by count).
- Decodes JMP/CALL/RET and issues load requests to the counter, using a hardware return-address stack.
- Squashes the wrong-path instructions already fetched.
- Forwards all other instructions to the execute stage.

---
 rtl/pc_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | pc_sequencer: JMP/CALL/RET control for program_counter, with return stack |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pc_sequencer #(
  parameter int COUNT_LIMIT = 255,
  parameter int COUNT_WIDTH = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [COUNT_WIDTH-1:0]             pc_addr,
  input  logic [INSTR_WIDTH-1:0]             instr,
  input  logic                               instr_valid,
  output logic                               pc_set,
  output logic [COUNT_WIDTH-1:0]             pc_set_value,
  output logic                               exec_valid,
  output logic [INSTR_WIDTH-1:0]             exec_instr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               stack_overflow,
  output logic                               stack_underflow
);

  localparam int c_DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int c_IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int c_SLOTS   = 1 << c_IDX_W;

  localparam logic [COUNT_WIDTH-1:0] c_LIMIT = COUNT_WIDTH'(COUNT_LIMIT);
  localparam logic [c_DEPTH_W-1:0]   c_FULL  = c_DEPTH_W'(STACK_DEPTH);
  localparam logic [c_DEPTH_W-1:0]   c_ONE   = c_DEPTH_W'(1);

  localparam logic [1:0] c_OP   = 2'b00;
  localparam logic [1:0] c_JMP  = 2'b01;
  localparam logic [1:0] c_CALL = 2'b10;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_SET   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [COUNT_WIDTH-1:0]  r_instr_addr;
  logic                    r_pc_set;
  logic [COUNT_WIDTH-1:0]  r_pc_set_value;
  logic                    r_exec_valid;
  logic [INSTR_WIDTH-1:0]  r_exec_instr;
  logic [c_DEPTH_W-1:0]    r_depth;
  logic                    r_ovf;
  logic                    r_unf;
  logic [COUNT_WIDTH-1:0]  r_stack [c_SLOTS];

  logic [1:0]              w_op;
  logic [COUNT_WIDTH-1:0]  w_target;
  logic [COUNT_WIDTH-1:0]  w_ret_addr;
  logic [COUNT_WIDTH-1:0]  w_pop_val;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_set_nxt;
  logic [COUNT_WIDTH-1:0]  w_set_val_nxt;
  logic                    w_exec_valid_nxt;
  logic [INSTR_WIDTH-1:0]  w_exec_instr_nxt;
  logic                    w_ovf_nxt;
  logic                    w_unf_nxt;

  assign w_op       = instr[INSTR_WIDTH-1:INSTR_WIDTH-2];
  assign w_target   = instr[COUNT_WIDTH-1:0];
  // Return address follows the counter's own wrap point, not a power of two.
  assign w_ret_addr = (r_instr_addr == c_LIMIT) ? '0 : r_instr_addr + COUNT_WIDTH'(1);
  assign w_full     = (r_depth == c_FULL);
  assign w_empty    = (r_depth == '0);
  assign w_pop_val  = r_stack[c_IDX_W'(r_depth - c_ONE)];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_set_nxt        = 1'b0;
    w_set_val_nxt    = r_pc_set_value;
    w_exec_valid_nxt = 1'b0;
    w_exec_instr_nxt = r_exec_instr;
    w_push           = 1'b0;
    w_pop            = 1'b0;
    w_ovf_nxt        = r_ovf;
    w_unf_nxt        = r_unf;
    case (r_state)
      S_RUN: begin
        if (instr_valid) begin
          case (w_op)
            c_OP: begin
              w_exec_valid_nxt = 1'b1;
              w_exec_instr_nxt = instr;
            end
            c_JMP: begin
              w_set_nxt     = 1'b1;
              w_set_val_nxt = w_target;
              w_state_nxt   = S_SET;
            end
            c_CALL: begin
              if (!w_full) begin
                w_push        = 1'b1;
                w_set_nxt     = 1'b1;
                w_set_val_nxt = w_target;
                w_state_nxt   = S_SET;
              end else begin
                w_ovf_nxt = 1'b1;
              end
            end
            default: begin
              if (!w_empty) begin
                w_pop         = 1'b1;
                w_set_nxt     = 1'b1;
                w_set_val_nxt = w_pop_val;
                w_state_nxt   = S_SET;
              end else begin
                w_unf_nxt = 1'b1;
              end
            end
          endcase
        end
      end
      // SET and FLUSH each discard one wrong-path fetch, valid or not.
      S_SET:   w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_addr   <= '0;
      r_pc_set       <= 1'b0;
      r_pc_set_value <= '0;
      r_exec_valid   <= 1'b0;
      r_exec_instr   <= '0;
      r_depth        <= '0;
      r_ovf          <= 1'b0;
      r_unf          <= 1'b0;
    end else begin
      r_instr_addr   <= pc_addr;
      r_pc_set       <= w_set_nxt;
      r_pc_set_value <= w_set_val_nxt;
      r_exec_valid   <= w_exec_valid_nxt;
      r_exec_instr   <= w_exec_instr_nxt;
      r_ovf          <= w_ovf_nxt;
      r_unf          <= w_unf_nxt;
      if (w_push) begin
        r_depth <= r_depth + c_ONE;
      end else if (w_pop) begin
        r_depth <= r_depth - c_ONE;
      end
    end
  end

  // Stack storage is deliberately not reset; only the depth pointer is.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_stack[c_IDX_W'(r_depth)] <= w_ret_addr;
    end
  end

  assign pc_set          = r_pc_set;
  assign pc_set_value    = r_pc_set_value;
  assign exec_valid      = r_exec_valid;
  assign exec_instr      = r_exec_instr;
  assign stack_depth     = r_depth;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_pc_sequencer: counter + sync ROM environment with scoreboarded outputs |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pc_sequencer;
  localparam int CW = 8;
  localparam int IW = 16;
  localparam int SD = 4;
  localparam int DW = $clog2(SD + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] pc_addr;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          pc_set;
  logic [CW-1:0] pc_set_value;
  logic          exec_valid;
  logic [IW-1:0] exec_instr;
  logic [DW-1:0] stack_depth;
  logic          stack_overflow;
  logic          stack_underflow;

  int checks   = 0;
  int failures = 0;

  logic [IW-1:0] rom_d [256];
  logic          rom_v [256];
  logic [IW-1:0] q_exec [$];
  logic [CW-1:0] q_set  [$];

  localparam logic [IW-1:0] RET = 16'hC000;

  always #5 clk = ~clk;

  pc_sequencer #(.COUNT_LIMIT(255), .COUNT_WIDTH(CW), .INSTR_WIDTH(IW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .instr(instr), .instr_valid(instr_valid),
    .pc_set(pc_set), .pc_set_value(pc_set_value), .exec_valid(exec_valid),
    .exec_instr(exec_instr), .stack_depth(stack_depth),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  // Attached program_counter and one-cycle-latency ROM; empty entries read as not-ready.
  always @(posedge clk) begin
    if (rst) begin
      pc_addr     <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (pc_set)              pc_addr <= pc_set_value;
      else if (pc_addr == 8'hFF) pc_addr <= '0;
      else                     pc_addr <= pc_addr + 8'd1;
      instr       <= rom_d[pc_addr];
      instr_valid <= rom_v[pc_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exec_valid) begin
      chk("exec_expected_pending", 32'(q_exec.size() != 0), 1);
      if (q_exec.size() != 0) chk("exec_instr_order", 32'(exec_instr), 32'(q_exec.pop_front()));
    end
    if (pc_set) begin
      chk("set_expected_pending", 32'(q_set.size() != 0), 1);
      if (q_set.size() != 0) chk("pc_set_value_order", 32'(pc_set_value), 32'(q_set.pop_front()));
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) begin
      rom_d[i] = '0;
      rom_v[i] = 1'b0;
    end
  endtask

  task automatic put(input int a, input logic [IW-1:0] d);
    rom_d[a] = d;
    rom_v[a] = 1'b1;
  endtask

  function automatic logic [IW-1:0] f_jmp(input logic [CW-1:0] t);
    return {2'b01, 6'b0, t};
  endfunction

  function automatic logic [IW-1:0] f_call(input logic [CW-1:0] t);
    return {2'b10, 6'b0, t};
  endfunction

  task automatic wait_exec(input logic [IW-1:0] v, input int bound, input string tag);
    int n = 0;
    while (!(exec_valid && exec_instr == v) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < bound), 1);
  endtask

  task automatic wait_set(input logic [CW-1:0] v, input int bound, input string tag);
    int n = 0;
    while (!(pc_set && pc_set_value == v) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < bound), 1);
  endtask

  task automatic queues_empty(input string tag);
    chk({tag, "_exec_q_empty"}, 32'(q_exec.size()), 0);
    chk({tag, "_set_q_empty"}, 32'(q_set.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);

    // Linear run
    rst = 1'b1;
    clear_rom();
    for (int i = 0; i < 4; i++) begin
      put(i, IW'(i + 1));
      q_exec.push_back(IW'(i + 1));
    end
    @(negedge clk);
    rst = 1'b0;
    chk("rst_pc_set", 32'(pc_set), 0);
    chk("rst_pc_set_value", 32'(pc_set_value), 0);
    chk("rst_exec_valid", 32'(exec_valid), 0);
    chk("rst_exec_instr", 32'(exec_instr), 0);
    chk("rst_stack_depth", 32'(stack_depth), 0);
    chk("rst_overflow", 32'(stack_overflow), 0);
    chk("rst_underflow", 32'(stack_underflow), 0);
    repeat (2) @(negedge clk);
    chk("lin_first_exec_valid", 32'(exec_valid), 1);
    chk("lin_first_exec_instr", 32'(exec_instr), 32'h0001);
    repeat (10) @(negedge clk);
    queues_empty("lin");

    // JMP with two wrong-path OPs behind it
    rst = 1'b1;
    clear_rom();
    put(5, f_jmp(8'h20));
    put(6, 16'h2AAA);
    put(7, 16'h3BBB);
    put(8'h20, 16'h1234);
    q_set.push_back(8'h20);
    q_exec.push_back(16'h1234);
    @(negedge clk);
    rst = 1'b0;
    wait_exec(16'h1234, 40, "jmp_target_exec_seen");
    chk("jmp_set_value_held", 32'(pc_set_value), 32'h20);
    chk("jmp_set_dropped", 32'(pc_set), 0);
    repeat (5) @(negedge clk);
    queues_empty("jmp");

    // CALL / RET
    rst = 1'b1;
    clear_rom();
    put(8'h10, f_call(8'h40));
    put(8'h40, RET);
    put(8'h11, 16'h1555);
    q_set.push_back(8'h40);
    q_set.push_back(8'h11);
    q_exec.push_back(16'h1555);
    @(negedge clk);
    rst = 1'b0;
    wait_set(8'h40, 40, "call_set_seen");
    chk("call_depth", 32'(stack_depth), 1);
    wait_set(8'h11, 10, "ret_set_seen");
    chk("ret_depth", 32'(stack_depth), 0);
    wait_exec(16'h1555, 10, "ret_exec_seen");
    repeat (5) @(negedge clk);
    chk("callret_no_underflow", 32'(stack_underflow), 0);
    chk("callret_no_overflow", 32'(stack_overflow), 0);
    queues_empty("callret");

    // Five nested CALLs against a 4-deep stack
    rst = 1'b1;
    clear_rom();
    put(8'h00, f_call(8'h10));
    put(8'h10, f_call(8'h20));
    put(8'h20, f_call(8'h30));
    put(8'h30, f_call(8'h40));
    put(8'h40, f_call(8'h50));
    put(8'h41, 16'h0141);
    put(8'h42, RET);
    put(8'h31, 16'h0131);
    q_set.push_back(8'h10);
    q_set.push_back(8'h20);
    q_set.push_back(8'h30);
    q_set.push_back(8'h40);
    q_set.push_back(8'h31);
    q_exec.push_back(16'h0141);
    q_exec.push_back(16'h0131);
    @(negedge clk);
    rst = 1'b0;
    wait_exec(16'h0141, 40, "ovf_fallthrough_exec_seen");
    chk("ovf_depth_full", 32'(stack_depth), 4);
    chk("ovf_flag", 32'(stack_overflow), 1);
    wait_exec(16'h0131, 10, "ovf_ret_exec_seen");
    chk("ovf_depth_after_ret", 32'(stack_depth), 3);
    repeat (3) @(negedge clk);
    queues_empty("ovf");

    // Underflow on empty RET, then CALL at COUNT_LIMIT wrapping its return to 0
    rst = 1'b1;
    clear_rom();
    put(8'h80, RET);
    put(8'hFF, f_call(8'h80));
    put(8'h00, 16'h0F0F);
    q_exec.push_back(16'h0F0F);
    q_set.push_back(8'h80);
    q_set.push_back(8'h00);
    q_exec.push_back(16'h0F0F);
    @(negedge clk);
    rst = 1'b0;
    wait_exec(16'h0F0F, 5, "wrap_first_exec_seen");
    repeat (200) @(negedge clk);
    chk("unf_flag", 32'(stack_underflow), 1);
    chk("unf_no_overflow", 32'(stack_overflow), 0);
    chk("unf_depth", 32'(stack_depth), 0);
    wait_set(8'h80, 100, "wrap_call_set_seen");
    chk("wrap_call_depth", 32'(stack_depth), 1);
    wait_set(8'h00, 10, "wrap_ret_set_seen");
    chk("wrap_ret_depth", 32'(stack_depth), 0);
    wait_exec(16'h0F0F, 10, "wrap_return_exec_seen");
    repeat (5) @(negedge clk);
    chk("unf_flag_sticky", 32'(stack_underflow), 1);
    queues_empty("wrap");

    // Reset landing in the SET cycle of a JMP
    rst = 1'b1;
    clear_rom();
    put(8'h00, RET);
    put(8'h01, f_call(8'h08));
    put(8'h08, 16'h0808);
    put(8'h09, f_jmp(8'h60));
    for (int p = 0; p < 2; p++) begin
      q_set.push_back(8'h08);
      q_exec.push_back(16'h0808);
      q_set.push_back(8'h60);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_set(8'h60, 20, "midrst_jmp_set_seen");
    chk("midrst_depth_before", 32'(stack_depth), 1);
    chk("midrst_unf_before", 32'(stack_underflow), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pc_set", 32'(pc_set), 0);
    chk("midrst_exec_valid", 32'(exec_valid), 0);
    chk("midrst_depth", 32'(stack_depth), 0);
    chk("midrst_underflow", 32'(stack_underflow), 0);
    chk("midrst_overflow", 32'(stack_overflow), 0);
    rst = 1'b0;
    wait_set(8'h60, 20, "midrst_resume_set_seen");
    chk("midrst_resume_depth", 32'(stack_depth), 1);
    repeat (5) @(negedge clk);
    queues_empty("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
